window_detector_sequencer: RTL
==============================

# window_detector_sequencer

Frame-level controller for the team's bit-serial two-output sliding-window detector. It accepts a W-bit parallel frame on a start strobe, clears the detector, and streams the frame into it LSB-first, one bit per cycle. It counts both detector hits per frame and reports the counts with a one-cycle done pulse. Every frame is therefore evaluated from a clean detector state, including after a sticky lock condition from the previous frame.

## Interface
- W, default 8: frame width in bits; W ≥ 2.
- CW, default 4: hit-counter width; must satisfy W < 2^CW.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  frame request; sampled only in IDLE.
- abort  in  1  cancels the frame in progress; synchronous; ignored outside SHIFT.
- frame  in  W  frame data, captured on the accepted start; bit 0 is sent first.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; cnt1/cnt2 are final while it is high.
- cnt1  out  CW  dec1 hits in the last or current frame.
- cnt2  out  CW  dec2 hits in the last or current frame.
- det_rst_n  out  1  synchronous active-low reset to the detector.
- det_in  out  1  serial bit to the detector.
- det_dec1  in  1  detector output 1; Mealy, valid in the same cycle as det_in.
- det_dec2  in  1  detector output 2; Mealy, valid in the same cycle as det_in.

## Operation
- FSM states: IDLE, SHIFT, DONE. The state, shift register (W bits), bit index, cnt1 and cnt2 are registers. busy, done, det_rst_n and det_in are decoded combinationally from the registered state.
- **IDLE**
  - det_rst_n=0, which holds the detector in reset. det_in=0, busy=0, done=0.
  - start=1 → capture frame into the shift register, set bit index=0, clear cnt1 and cnt2, go to SHIFT.
- **SHIFT**
  - det_rst_n=1, det_in=shift register bit 0, busy=1.
  - Each cycle: cnt1 += det_dec1 and cnt2 += det_dec2, both saturating at 2^CW−1. Shift the register right, fill with 0. Increment the bit index.
  - After the cycle with bit index = W−1 → DONE.
  - abort=1 in any SHIFT cycle → IDLE. That cycle's det_dec1/det_dec2 are still counted. No done pulse is issued. The counts keep their partial values.
- **DONE**
  - done=1, busy=0, det_rst_n=0, det_in=0.
  - Unconditionally goes to IDLE after one cycle.
  - start during DONE is ignored; it is accepted only once the FSM is back in IDLE.
- Boundary and priority rules:
  - start while busy: ignored; frame and counts are unaffected.
  - abort together with the last bit: abort wins → IDLE, no done pulse.
  - abort outside SHIFT: no effect.
  - cnt1/cnt2 change only during SHIFT and when a start is accepted (cleared). They hold between frames.
- Reset (any cycle, including mid-frame):
  - state=IDLE, shift register=0, bit index=0, cnt1=cnt2=0.
  - Resulting outputs: busy=0, done=0, det_rst_n=0, det_in=0.
  - The interrupted frame produces no done pulse.

## Timing
- start sampled high in IDLE during cycle k → bits are sent in cycles k+1 … k+W, with det_in=frame[i] in cycle k+1+i.
- The detector sees det_rst_n=0 during cycle k, so it begins cycle k+1 in its cleared state.
- cnt1/cnt2 after cycle k+1+i include the hits for bits 0…i.
- done=1 in cycle k+W+1.
- The next start can be accepted in cycle k+W+2 at the earliest. Throughput is one frame per W+2 cycles.
- det_dec1/det_dec2 are sampled at the end of the same cycle that drives det_in. There is no extra pipeline stage.

## Test plan
(W=8, CW=4, bench drives the team's two-output detector. dec1 detects 1,0,1 with overlap, and sticks off after four consecutive 1s until reset. dec2 detects two or more 1s, then 0, then 1.)
- **Basic frame:** reset, then start with frame=8'hB5. Required: det_in sequence 1,0,1,0,1,1,0,1 in cycles k+1…k+8; done in cycle k+9; cnt1=3, cnt2=1; busy high for exactly 8 cycles.
- **Lock, then clean restart:** frame=8'hAF → cnt1=0, cnt2=1. Then frame=8'hB5 → cnt1=3, cnt2=1, which shows det_rst_n=0 between frames cleared the lock.
- **start while busy:** pulse start with frame=8'h00 during cycle k+4 of an 8'hB5 frame. Required: ignored; results are cnt1=3, cnt2=1; exactly one done pulse.
- **Abort:** assert abort in cycle k+3 of an 8'hB5 frame. Required: IDLE in cycle k+4, no done pulse, cnt1=1, cnt2=0 held; det_rst_n=0 from cycle k+4.
- **Reset mid-frame:** rst_n=0 in cycle k+5. Required: in the next cycle, busy=0, done=0, cnt1=cnt2=0, det_rst_n=0, det_in=0; no done pulse; a new 8'hB5 frame then gives cnt1=3, cnt2=1.
- **Back-to-back frames:** start held high continuously. Required: frames accepted every 10 cycles, start in DONE ignored, one done pulse per frame.

Source files
------------

// File: rtl/window_detector_sequencer.sv
// Frame controller for the bit-serial two-output window detector: clears the detector,
// streams a captured W-bit frame LSB-first, and counts dec1/dec2 hits per frame.
module window_detector_sequencer #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  frame,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic          det_rst_n,
  output logic          det_in,
  input  logic          det_dec1,
  input  logic          det_dec2
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt1_q, cnt1_d;
  logic [CW-1:0]  cnt2_q, cnt2_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = frame;
          idx_d   = '0;
          cnt1_d  = '0;
          cnt2_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Hits in the abort cycle still count; abort outranks the last-bit exit.
        if (det_dec1 && (cnt1_q != {CW{1'b1}})) cnt1_d = cnt1_q + CW'(1);
        if (det_dec2 && (cnt2_q != {CW{1'b1}})) cnt2_d = cnt2_q + CW'(1);
        sr_d  = {1'b0, sr_q[W-1:1]};
        idx_d = idx_q + IW'(1);
        if (abort)                       state_d = S_IDLE;
        else if (idx_q == IW'(W - 1))    state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
    end
  end

  // The detector is held in reset whenever no bit is being streamed.
  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign det_rst_n = busy;
  assign det_in    = busy & sr_q[0];
  assign cnt1      = cnt1_q;
  assign cnt2      = cnt2_q;

endmodule
